pll_phase_resp: RTL and testbench
=================================

# pll_phase_resp

Synthesizable responder for the PLL dynamic phase-shift handshake. It sits on the PLL side of PHASESTEP, PHASEUPDOWN, PHASECOUNTERSELECT and PHASEDONE, where it stands in for the PLL in simulation and on-chip loopback. It accepts step requests from the phase-shift controller, tracks the accumulated phase of the M counter and each Cn counter, and drives PHASEDONE with PLL-like busy timing. It also flags protocol violations for the register interface.

## Interface
Parameters:
- NUM_CNT, 5, number of Cn output counters (C0..C4).
- PH_W, 6, width of each phase accumulator.
- PH_MOD, 64, phase modulus in steps; must be ≤ 2**PH_W.
- MIN_STEP, 2, minimum PHASESTEP high width in cycles.
- DONE_DLY, 4, cycles PHASEDONE stays low per accepted step; must be ≥ 1.

Ports:
- CLK50M, in, 1, clock.
- RESET_N, in, 1, reset; asynchronous, active-low.
- PHASESTEP, in, 1, step request.
- PHASEUPDOWN, in, 1, direction: 1 = up, 0 = down.
- PHASECOUNTERSELECT, in, 4, selects the target: 0 = all Cn, 1 = M, 2..NUM_CNT+1 = C0..C(NUM_CNT-1).
- PHASEDONE, out, 1, ready/done (high = idle).
- PHASE_M, out, PH_W, accumulated M phase.
- PHASE_C, out, NUM_CNT*PH_W, packed Cn phases; C0 occupies the LSBs.
- STEP_CNT, out, 16, accepted-step counter; wraps at 16'hFFFF→0.
- ERR_CLR, in, 1, synchronous clear of all error flags.
- ERR_SHORT, out, 1, sticky; set by a PHASESTEP pulse shorter than MIN_STEP.
- ERR_SEL, out, 1, sticky; set by a select value > NUM_CNT+1.
- ERR_BUSY, out, 1, sticky; set by a PHASESTEP rise while busy.

## Operation
- Reset values: PHASEDONE=1, all phases=0, STEP_CNT=0, all ERR_*=0, FSM=IDLE. Reset is honoured mid-operation, with no update of the pending step.
- FSM states: IDLE, ARMED, BUSY.
- IDLE:
  - PHASESTEP sampled 1 → ARMED; width counter set to 1.
- ARMED:
  - While PHASESTEP=1, the width counter increments and saturates at MIN_STEP.
  - PHASEUPDOWN and PHASECOUNTERSELECT are captured every high cycle; the values from the last high cycle are the ones used.
  - PHASESTEP sampled 0 with width ≥ MIN_STEP → BUSY; PHASEDONE←0; delay counter←DONE_DLY-1.
  - PHASESTEP sampled 0 with width < MIN_STEP → IDLE; ERR_SHORT←1; no step, no PHASEDONE activity.
- BUSY:
  - The delay counter decrements each cycle.
  - On the edge where the counter is 0: apply the update, STEP_CNT+1, PHASEDONE←1, → IDLE.
  - A PHASESTEP rise while in BUSY is ignored and sets ERR_BUSY. The responder does not enter ARMED until PHASESTEP is sampled 0 in IDLE.
- Update arithmetic:
  - up: p = (p+1 == PH_MOD) ? 0 : p+1.
  - down: p = (p == 0) ? PH_MOD-1 : p-1.
  - Select 0 updates every Cn but not M.
  - Select 1 updates M only.
  - An invalid select sets ERR_SEL (at ARMED→BUSY). The handshake still completes and STEP_CNT still increments, but no phase changes.
- ERR_CLR has priority below any set event in the same cycle: set wins.

## Timing
- Let t be the edge at which PHASESTEP is first sampled low after a valid pulse.
- PHASEDONE is low in cycles t+1 .. t+DONE_DLY and high from t+DONE_DLY+1 on.
- The phase/STEP_CNT update becomes visible in the same cycle PHASEDONE returns high.
- Minimum step-to-step period: MIN_STEP + DONE_DLY + 1 cycles.
- No combinational path from inputs to outputs; all outputs are registered.

## Configuration
- PLL_PHASE_RESP_ERR_EN defined:
  - ERR_SHORT, ERR_SEL and ERR_BUSY are implemented as above.
  - Pulses shorter than MIN_STEP are rejected.
- PLL_PHASE_RESP_ERR_EN undefined:
  - ERR_* are tied to 0 and ERR_CLR is ignored.
  - Any PHASESTEP pulse of ≥ 1 cycle is accepted as a valid step.
  - Invalid selects still change no phase.

## Structure
- Package pll_phase_pkg holds:
  - the FSM state enum (IDLE, ARMED, BUSY);
  - select constants SEL_ALL=0, SEL_M=1, SEL_C0=2;
  - direction constants PH_UP=1'b1, PH_DN=1'b0.
- Sub-module pll_phase_acc: one modular up/down accumulator (ports: clk, rst_n, en, up, phase). It is instantiated NUM_CNT+1 times; the top level holds the FSM, counters and error logic.

## Test plan
- Reset → PHASEDONE=1, PHASE_M=0, PHASE_C all 0, STEP_CNT=0, ERR_*=0.
- Select 2, up, PHASESTEP high 4 cycles → PHASEDONE low exactly 4 cycles starting 1 cycle after the fall; then C0=1, others 0, STEP_CNT=1.
- Select 0, down, one step from reset → every Cn=63, PHASE_M=0; repeat with select 1, up, 64 times → PHASE_M wraps back to 0.
- PHASESTEP high 1 cycle → with the macro: ERR_SHORT=1, no PHASEDONE drop, STEP_CNT unchanged; without the macro: a step is taken.
- Select 9 → handshake completes, no phase change, STEP_CNT+1, ERR_SEL=1; ERR_CLR pulse → ERR_SEL=0.
- PHASESTEP re-raised during BUSY → ERR_BUSY=1, only one step applied. Separately, RESET_N low mid-BUSY → PHASEDONE=1 and all phases 0 immediately.

Source files
------------

// File: rtl/pll_phase_pkg.sv
// pll_phase_pkg: shared FSM state, select and direction constants for the PLL phase-shift responder.
package pll_phase_pkg;
   typedef enum logic [1:0] {IDLE, ARMED, BUSY} state_t;
   localparam logic [3:0] SEL_ALL = 4'd0;
   localparam logic [3:0] SEL_M = 4'd1;
   localparam logic [3:0] SEL_C0 = 4'd2;
   localparam logic PH_UP = 1'b1;
   localparam logic PH_DN = 1'b0;
endpackage

// File: rtl/pll_phase_acc.sv
// pll_phase_acc: modular up/down phase accumulator, one per PLL counter.
module pll_phase_acc
   import pll_phase_pkg::*;
#(
   parameter int PH_W = 6,
   parameter int PH_MOD = 64
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            en,
   input  logic            up,
   output logic [PH_W-1:0] phase
);
   logic [PH_W-1:0] inc, dec;
   // PH_MOD may equal 2**PH_W, so the wrap test is done in integer width
   always_comb begin
      inc = (int'(phase) + 1 == PH_MOD) ? '0 : phase + PH_W'(1);
      dec = (phase == '0) ? PH_W'(PH_MOD - 1) : phase - PH_W'(1);
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) phase <= '0;
      else if (en) phase <= (up == PH_UP) ? inc : dec;
endmodule

// File: rtl/pll_phase_resp.sv
// pll_phase_resp: PLL-side responder for the dynamic phase-shift handshake.
// Define PLL_PHASE_RESP_ERR_EN to enable short-pulse rejection and the sticky ERR_* flags.
module pll_phase_resp
   import pll_phase_pkg::*;
#(
   parameter int NUM_CNT = 5,
   parameter int PH_W = 6,
   parameter int PH_MOD = 64,
   parameter int MIN_STEP = 2,
   parameter int DONE_DLY = 4
) (
   input  logic                    CLK50M,
   input  logic                    RESET_N,
   input  logic                    PHASESTEP,
   input  logic                    PHASEUPDOWN,
   input  logic [3:0]              PHASECOUNTERSELECT,
   output logic                    PHASEDONE,
   output logic [PH_W-1:0]         PHASE_M,
   output logic [NUM_CNT*PH_W-1:0] PHASE_C,
   output logic [15:0]             STEP_CNT,
   input  logic                    ERR_CLR,
   output logic                    ERR_SHORT,
   output logic                    ERR_SEL,
   output logic                    ERR_BUSY
);
   localparam int WC_W = $clog2(MIN_STEP + 1);
   localparam int DC_W = $clog2(DONE_DLY + 1);
`ifdef PLL_PHASE_RESP_ERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif
   state_t state;
   logic [WC_W-1:0] wcnt;
   logic [DC_W-1:0] dcnt;
   logic [3:0] sel_q;
   logic up_q, block, long_ok, sel_bad, fall, fire, en_m;
   logic [NUM_CNT-1:0] en_c;
   always_comb begin
      long_ok = !ERR_EN || (wcnt >= WC_W'(MIN_STEP));
      sel_bad = int'(sel_q) > NUM_CNT + 1;
      fall = (state == ARMED) && !PHASESTEP;
      fire = (state == BUSY) && (dcnt == '0);
      en_m = fire && (sel_q == SEL_M);
   end
   // block holds off re-arming after PHASESTEP was seen during BUSY until it is seen low in IDLE
   always_ff @(posedge CLK50M or negedge RESET_N)
      if (!RESET_N) begin
         state <= IDLE;
         wcnt <= '0;
         dcnt <= '0;
         sel_q <= SEL_ALL;
         up_q <= PH_DN;
         block <= 1'b0;
         PHASEDONE <= 1'b1;
         STEP_CNT <= '0;
      end else begin
         case (state)
            IDLE:
               if (block) block <= PHASESTEP;
               else if (PHASESTEP) begin
                  state <= ARMED;
                  wcnt <= WC_W'(1);
                  sel_q <= PHASECOUNTERSELECT;
                  up_q <= PHASEUPDOWN;
               end
            ARMED:
               if (PHASESTEP) begin
                  if (wcnt != WC_W'(MIN_STEP)) wcnt <= wcnt + WC_W'(1);
                  sel_q <= PHASECOUNTERSELECT;
                  up_q <= PHASEUPDOWN;
               end else if (long_ok) begin
                  state <= BUSY;
                  PHASEDONE <= 1'b0;
                  dcnt <= DC_W'(DONE_DLY - 1);
               end else state <= IDLE;
            BUSY: begin
               if (PHASESTEP) block <= 1'b1;
               if (dcnt == '0) begin
                  state <= IDLE;
                  PHASEDONE <= 1'b1;
                  STEP_CNT <= STEP_CNT + 16'd1;
               end else dcnt <= dcnt - DC_W'(1);
            end
            default: state <= IDLE;
         endcase
      end
   pll_phase_acc #(.PH_W(PH_W), .PH_MOD(PH_MOD)) u_acc_m (
      .clk(CLK50M), .rst_n(RESET_N), .en(en_m), .up(up_q), .phase(PHASE_M)
   );
   for (genvar i = 0; i < NUM_CNT; i++) begin : g_c
      assign en_c[i] = fire && ((sel_q == SEL_ALL) || (int'(sel_q) == int'(SEL_C0) + i));
      pll_phase_acc #(.PH_W(PH_W), .PH_MOD(PH_MOD)) u_acc (
         .clk(CLK50M), .rst_n(RESET_N), .en(en_c[i]), .up(up_q), .phase(PHASE_C[i*PH_W +: PH_W])
      );
   end
`ifdef PLL_PHASE_RESP_ERR_EN
   logic step_q;
   // a set event in the same cycle as ERR_CLR wins
   always_ff @(posedge CLK50M or negedge RESET_N)
      if (!RESET_N) begin
         step_q <= 1'b0;
         ERR_SHORT <= 1'b0;
         ERR_SEL <= 1'b0;
         ERR_BUSY <= 1'b0;
      end else begin
         step_q <= PHASESTEP;
         ERR_SHORT <= (fall && !long_ok) || (ERR_SHORT && !ERR_CLR);
         ERR_SEL <= (fall && long_ok && sel_bad) || (ERR_SEL && !ERR_CLR);
         ERR_BUSY <= ((state == BUSY) && PHASESTEP && !step_q) || (ERR_BUSY && !ERR_CLR);
      end
`else
   logic unused_err;
   assign unused_err = ERR_CLR ^ sel_bad ^ fall;
   assign ERR_SHORT = 1'b0;
   assign ERR_SEL = 1'b0;
   assign ERR_BUSY = 1'b0;
`endif
endmodule

// File: tb/tb_pll_phase_resp.sv
// tb_pll_phase_resp: directed self-checking bench for pll_phase_resp.
module tb_pll_phase_resp;
   import pll_phase_pkg::*;
`ifdef PLL_PHASE_RESP_ERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif
   logic CLK50M = 1'b0, RESET_N = 1'b0;
   logic PHASESTEP = 1'b0, PHASEUPDOWN = 1'b0, ERR_CLR = 1'b0;
   logic [3:0] PHASECOUNTERSELECT = 4'd0;
   logic PHASEDONE, ERR_SHORT, ERR_SEL, ERR_BUSY;
   logic [5:0] PHASE_M;
   logic [29:0] PHASE_C;
   logic [15:0] STEP_CNT;
   int n_asrt = 0, n_fail = 0, lows;
   logic [29:0] exp_c;
   logic [15:0] exp_cnt;

   pll_phase_resp dut (
      .CLK50M(CLK50M), .RESET_N(RESET_N), .PHASESTEP(PHASESTEP), .PHASEUPDOWN(PHASEUPDOWN),
      .PHASECOUNTERSELECT(PHASECOUNTERSELECT), .PHASEDONE(PHASEDONE), .PHASE_M(PHASE_M),
      .PHASE_C(PHASE_C), .STEP_CNT(STEP_CNT), .ERR_CLR(ERR_CLR), .ERR_SHORT(ERR_SHORT),
      .ERR_SEL(ERR_SEL), .ERR_BUSY(ERR_BUSY)
   );

   always #10 CLK50M = ~CLK50M;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_asrt++;
      assert (obs === exp_v) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   // called on a falling edge; returns on the first falling edge with PHASEDONE high after the pulse
   task automatic step(input logic [3:0] sel, input logic up, input int w, output int lo);
      PHASECOUNTERSELECT = sel;
      PHASEUPDOWN = up;
      PHASESTEP = 1'b1;
      repeat (w) @(negedge CLK50M);
      PHASESTEP = 1'b0;
      lo = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge CLK50M);
         if (PHASEDONE) break;
         lo++;
      end
   endtask

   task automatic do_reset();
      RESET_N = 1'b0;
      PHASESTEP = 1'b0;
      repeat (2) @(negedge CLK50M);
      RESET_N = 1'b1;
      @(negedge CLK50M);
   endtask

   initial begin
      repeat (3) @(negedge CLK50M);
      chk("rst_done", 32'(PHASEDONE), 32'd1);
      chk("rst_m", 32'(PHASE_M), 32'd0);
      chk("rst_c", 32'(PHASE_C), 32'd0);
      chk("rst_cnt", 32'(STEP_CNT), 32'd0);
      chk("rst_err", 32'({ERR_SHORT, ERR_SEL, ERR_BUSY}), 32'd0);
      RESET_N = 1'b1;
      @(negedge CLK50M);

      step(SEL_C0, PH_UP, 4, lows);
      chk("c0_lows", 32'(lows), 32'd4);
      chk("c0_c", 32'(PHASE_C), 32'h1);
      chk("c0_m", 32'(PHASE_M), 32'd0);
      chk("c0_cnt", 32'(STEP_CNT), 32'd1);

      do_reset();
      step(SEL_ALL, PH_DN, 2, lows);
      chk("all_lows", 32'(lows), 32'd4);
      chk("all_c", 32'(PHASE_C), 32'h3FFFFFFF);
      chk("all_m", 32'(PHASE_M), 32'd0);

      for (int i = 0; i < 63; i++) step(SEL_M, PH_UP, 2, lows);
      chk("m_63", 32'(PHASE_M), 32'd63);
      step(SEL_M, PH_UP, 2, lows);
      chk("m_wrap", 32'(PHASE_M), 32'd0);
      chk("m_c", 32'(PHASE_C), 32'h3FFFFFFF);
      chk("m_cnt", 32'(STEP_CNT), 32'd65);

      step(SEL_C0, PH_UP, 1, lows);
      exp_c = ERR_EN ? 30'h3FFFFFFF : 30'h3FFFFFC0;
      exp_cnt = ERR_EN ? 16'd65 : 16'd66;
      chk("short_lows", 32'(lows), ERR_EN ? 32'd0 : 32'd4);
      chk("short_err", 32'(ERR_SHORT), 32'(ERR_EN));
      chk("short_cnt", 32'(STEP_CNT), 32'(exp_cnt));
      chk("short_c", 32'(PHASE_C), 32'(exp_c));

      step(4'd9, PH_UP, 2, lows);
      exp_cnt = exp_cnt + 16'd1;
      chk("sel9_lows", 32'(lows), 32'd4);
      chk("sel9_cnt", 32'(STEP_CNT), 32'(exp_cnt));
      chk("sel9_c", 32'(PHASE_C), 32'(exp_c));
      chk("sel9_m", 32'(PHASE_M), 32'd0);
      chk("sel9_err", 32'(ERR_SEL), 32'(ERR_EN));
      ERR_CLR = 1'b1;
      @(negedge CLK50M);
      ERR_CLR = 1'b0;
      @(negedge CLK50M);
      chk("clr_err", 32'({ERR_SHORT, ERR_SEL, ERR_BUSY}), 32'd0);

      PHASECOUNTERSELECT = SEL_C0;
      PHASEUPDOWN = PH_UP;
      PHASESTEP = 1'b1;
      repeat (2) @(negedge CLK50M);
      PHASESTEP = 1'b0;
      @(negedge CLK50M);
      chk("busy_done", 32'(PHASEDONE), 32'd0);
      repeat (2) @(negedge CLK50M);
      PHASESTEP = 1'b1;
      repeat (4) @(negedge CLK50M);
      PHASESTEP = 1'b0;
      repeat (10) @(negedge CLK50M);
      exp_c = ERR_EN ? 30'h3FFFFFC0 : 30'h3FFFFFC1;
      exp_cnt = exp_cnt + 16'd1;
      chk("busy_cnt", 32'(STEP_CNT), 32'(exp_cnt));
      chk("busy_c", 32'(PHASE_C), 32'(exp_c));
      chk("busy_err", 32'(ERR_BUSY), 32'(ERR_EN));
      chk("busy_idle", 32'(PHASEDONE), 32'd1);

      PHASECOUNTERSELECT = SEL_M;
      PHASESTEP = 1'b1;
      repeat (2) @(negedge CLK50M);
      PHASESTEP = 1'b0;
      @(negedge CLK50M);
      chk("mid_done", 32'(PHASEDONE), 32'd0);
      RESET_N = 1'b0;
      #1;
      chk("mid_rdone", 32'(PHASEDONE), 32'd1);
      chk("mid_m", 32'(PHASE_M), 32'd0);
      chk("mid_c", 32'(PHASE_C), 32'd0);
      chk("mid_cnt", 32'(STEP_CNT), 32'd0);
      @(negedge CLK50M);
      RESET_N = 1'b1;
      repeat (8) @(negedge CLK50M);
      chk("mid_after", 32'(PHASE_M), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
      $finish;
   end
endmodule
